gpr_file: RTL
=============

// Module: gpr_file
// PURPOSE
//  Parametrised general-purpose register file for the microprocessor datapath.
//  - Bus port: one handshaked read/write port (cs/read/rdy) for the control unit.
//  - Datapath ports: two independent registered read ports (A, B) feeding the ALU operands.
//  - Adds reset, range checking and optional write-to-read forwarding.
// PARAMETERS
//  DATA_WIDTH     16   width of each register and of all data ports
//  ADDR_WIDTH     16   width of the bus address
//  DEPTH          8    number of registers; must be >= 2
//  IDX_W   $clog2(DEPTH)  localparam; register index width
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous, active-low reset
//  cs         in   1           bus request; held high until rdy returns, then dropped
//  read       in   1           1 = read, 0 = write; sampled with cs in IDLE
//  address    in   ADDR_WIDTH  bus register address
//  wdata      in   DATA_WIDTH  bus write data; sampled with cs in IDLE
//  rdata      out  DATA_WIDTH  bus read data; valid while state == DONE
//  rdy        out  1           1 = idle or transfer complete
//  err        out  1           address >= DEPTH on the current transfer
//  ra_addr    in   IDX_W       read port A index
//  rb_addr    in   IDX_W       read port B index
//  ra_data    out  DATA_WIDTH  GPR[ra_addr], registered, 1-cycle latency
//  rb_data    out  DATA_WIDTH  GPR[rb_addr], registered, 1-cycle latency
// BEHAVIOUR
//  Reset (rst_n low, async)
//   - All GPR = 0; state = IDLE.
//   - rdy = 1; rdata, err, ra_data, rb_data = 0.
//  Bus FSM (IDLE -> ACCESS -> DONE -> IDLE)
//   - IDLE: rdy = 1. If cs = 1, latch read, address and wdata; go to ACCESS.
//   - ACCESS: rdy = 0, one cycle.
//     - Write in range: GPR[address[IDX_W-1:0]] <= wdata.
//     - Read in range: rdata <= GPR[index].
//     - Out of range (address >= DEPTH): no write; rdata <= 0; err <= 1.
//     - Then go to DONE.
//   - DONE: rdy = 1; rdata and err held. Stay while cs = 1; when cs = 0 go to IDLE and clear err.
//  Latency and timing
//   - Bus: rdy falls 1 cycle after cs is sampled; rises 2 cycles after.
//   - A new request needs cs low for >= 1 cycle.
//   - rdata is driven at all times (no tristate); holds its last value outside DONE.
//  Read ports
//   - Every cycle: ra_data <= GPR[ra_addr]; rb_data <= GPR[rb_addr].
//   - Independent of the FSM; A and B may use the same index.
//   - ra_addr/rb_addr >= DEPTH returns 0.
//  Boundary cases
//   - Write and port read of the same index in the same cycle: port returns the OLD value
//     (unless GPR_BYPASS_EN).
//   - Reset in ACCESS: any pending write is aborted; registers are cleared.
//   - A change of cs/read/address/wdata after the IDLE sample is ignored until the next IDLE.
// CONFIGURATION
//  GPR_BYPASS_EN defined
//   - When a bus write commits in ACCESS and ra_addr/rb_addr equals the write index,
//     that port captures wdata (the new value) in the same cycle.
//  GPR_BYPASS_EN undefined
//   - Read ports always see pre-write contents.
// STRUCTURE
//  Package gpr_pkg
//   - Bus FSM state encoding: IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2.
//   - Default width/depth constants.
//  Sub-module gpr_read_port
//   - Registered index-to-data mux with range check and bypass compare.
//   - Instantiated twice (A, B).
//  Storage array and bus FSM live in gpr_file itself.
// TESTING
//  1. Reset
//     - Hold rst_n = 0 mid-stream -> rdy = 1, err = 0, rdata = 0, ra_data = rb_data = 0, all GPR = 0.
//  2. Bus write/read
//     - Write 16'hA5A5 to addr 3, then read addr 3
//       -> rdy low exactly 1 cycle per transfer; rdata = 16'hA5A5 in DONE.
//  3. Out-of-range address
//     - Write 16'hFFFF to addr 8 (DEPTH = 8) -> err = 1 in DONE; GPR unchanged.
//     - Read addr 8 -> rdata = 0, err = 1.
//  4. Dual read ports
//     - Preload GPR[1] = 16'h0011, GPR[6] = 16'h0066; set ra_addr = 1, rb_addr = 6
//       -> next cycle ra_data = 16'h0011, rb_data = 16'h0066.
//     - Set ra_addr = rb_addr = 6 -> both 16'h0066.
//  5. Write/read collision
//     - GPR[2] = 16'h1234; bus writes 16'h5678 to addr 2 while ra_addr = 2
//       -> ra_data = 16'h1234 without GPR_BYPASS_EN, 16'h5678 with it.
//  6. Handshake and reset abort
//     - Hold cs high after DONE for 3 cycles -> stays DONE, no second write.
//     - Assert rst_n = 0 during ACCESS of a write -> target register = 0 after reset.

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared defaults and bus FSM state encoding for the general-purpose register file.
package gpr_pkg;

  localparam int GPR_DATA_W = 16;
  localparam int GPR_ADDR_W = 16;
  localparam int GPR_DEPTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } gpr_state_e;

endpackage

// File: rtl/gpr_read_port.sv
// Registered register-file read port: index mux with range check and write bypass.
// Latency 1 cycle; no backpressure, a new index is accepted every cycle.
module gpr_read_port
  import gpr_pkg::*;
#(
  parameter int DATA_WIDTH = GPR_DATA_W,
  parameter int DEPTH      = GPR_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [$clog2(DEPTH)-1:0]      rd_idx,
  input  logic [DEPTH*DATA_WIDTH-1:0]   regs_flat,
  input  logic                          byp_vld,
  input  logic [$clog2(DEPTH)-1:0]      byp_idx,
  input  logic [DATA_WIDTH-1:0]         byp_dat,
  output logic [DATA_WIDTH-1:0]         rd_dat
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] rd_dat_d;
  logic [DATA_WIDTH-1:0] rd_dat_q;

  // Only indices below DEPTH match an entry, so anything else reads as zero.
  always_comb begin
    rd_dat_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_dat_d = regs_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (byp_vld && (byp_idx == rd_idx)) begin
      rd_dat_d = byp_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dat_q <= '0;
    end else begin
      rd_dat_q <= rd_dat_d;
    end
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/gpr_file.sv
// Register file with a handshaked bus port (IDLE->ACCESS->DONE) and two registered read ports.
// Bus: rdy low for the single ACCESS cycle, DONE held while cs stays high; ports 1-cycle latency. Define GPR_BYPASS_EN to forward bus writes to the ports.
module gpr_file
  import gpr_pkg::*;
#(
  parameter int DATA_WIDTH = GPR_DATA_W,
  parameter int ADDR_WIDTH = GPR_ADDR_W,
  parameter int DEPTH      = GPR_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cs,
  input  logic                      read,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      rdy,
  output logic                      err,
  input  logic [$clog2(DEPTH)-1:0]  ra_addr,
  input  logic [$clog2(DEPTH)-1:0]  rb_addr,
  output logic [DATA_WIDTH-1:0]     ra_data,
  output logic [DATA_WIDTH-1:0]     rb_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  gpr_state_e             state_q, state_d;
  logic                   read_q, read_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [DATA_WIDTH-1:0]  gpr_q [DEPTH];
  logic [DATA_WIDTH-1:0]  gpr_d [DEPTH];

  logic                   in_range;
  logic [IDX_W-1:0]       idx;
  logic                   wr_commit;
  logic                   byp_vld;
  logic [DEPTH*DATA_WIDTH-1:0] gpr_flat;

  // The full latched address is compared, so high address bits make a transfer out of range.
  assign in_range  = (addr_q < DEPTH_A);
  assign idx       = addr_q[IDX_W-1:0];
  assign wr_commit = (state_q == ST_ACCESS) && !read_q && in_range;

`ifdef GPR_BYPASS_EN
  assign byp_vld = wr_commit;
`else
  assign byp_vld = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cs) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE:   if (!cs) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdy = 1'b1;
    if (state_q == ST_ACCESS) rdy = 1'b0;
  end

  // Request fields are captured only in IDLE; later bus changes are ignored until the next IDLE.
  always_comb begin
    read_d  = read_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    gpr_d   = gpr_q;
    case (state_q)
      ST_IDLE: begin
        if (cs) begin
          read_d  = read;
          addr_d  = address;
          wdata_d = wdata;
        end
      end
      ST_ACCESS: begin
        err_d = !in_range;
        if (!in_range) begin
          rdata_d = '0;
        end else if (read_q) begin
          rdata_d = gpr_q[idx];
        end
        if (wr_commit) gpr_d[idx] = wdata_q;
      end
      ST_DONE: begin
        if (!cs) err_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) gpr_q[i] <= '0;
    end else begin
      read_q  <= read_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      gpr_q   <= gpr_d;
    end
  end

  always_comb begin
    gpr_flat = '0;
    for (int i = 0; i < DEPTH; i++) gpr_flat[i*DATA_WIDTH +: DATA_WIDTH] = gpr_q[i];
  end

  gpr_read_port #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_port_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (ra_addr),
    .regs_flat (gpr_flat),
    .byp_vld   (byp_vld),
    .byp_idx   (idx),
    .byp_dat   (wdata_q),
    .rd_dat    (ra_data)
  );

  gpr_read_port #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_port_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (rb_addr),
    .regs_flat (gpr_flat),
    .byp_vld   (byp_vld),
    .byp_idx   (idx),
    .byp_dat   (wdata_q),
    .rd_dat    (rb_data)
  );

  assign rdata = rdata_q;
  assign err   = err_q;

endmodule
